// File: rtl/tlb_lookup_pipe.sv
// Multi-port, two-stage TLB lookup. Each port registers a match vector in s1,
// then priority-encodes it into a registered result in s2.
package tlb_pkg;
    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef struct packed {
        logic        miss;
        logic [5:0]  which;
        logic [31:0] phy_addr;
        logic        dirty;
        logic        valid;
        logic [2:0]  cache_flag;
    } tlb_result_t;
endpackage

module tlb_lookup_lane
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  tlb_entry_t [ENTRIES-1:0]  entries,
    input  logic                      tlb_we,
    input  logic [7:0]                asid,
    input  logic                      req_valid,
    input  logic [31:0]               req_vaddr,
    output logic                      req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output tlb_result_t               resp_result,
    output logic                      resp_multi,
    output logic [CNT_W-1:0]          hit_cnt,
    output logic [CNT_W-1:0]          miss_cnt
);
    function automatic logic [ENTRIES-1:0] match_vec(input logic [31:0] va,
                                                     input tlb_entry_t [ENTRIES-1:0] ents,
                                                     input logic [7:0] cur_asid);
        logic [ENTRIES-1:0] m;
        m = '0;
        for (int i = 0; i < ENTRIES; i++)
            m[i] = (ents[i].vpn2 == va[31:13]) && ((ents[i].asid == cur_asid) || ents[i].g);
        return m;
    endfunction

    logic               s1_valid, s1_stale;
    logic [31:0]        s1_vaddr;
    logic [ENTRIES-1:0] s1_match, s1_cur;
    logic               s1_xfer, accept;
    logic               sel_hit, sel_multi;
    logic [5:0]         sel_which;
    tlb_entry_t         sel_ent;
    tlb_result_t        res;

    // A stale s1 looks up again against the entries as they are now.
    assign s1_cur    = s1_stale ? match_vec(s1_vaddr, entries, asid) : s1_match;
    assign s1_xfer   = s1_valid && !tlb_we && !flush && (!resp_valid || resp_ready);
    assign req_ready = !flush && (!s1_valid || s1_xfer);
    assign accept    = req_valid && req_ready;

    always_comb begin
        sel_hit   = 1'b0;
        sel_multi = 1'b0;
        sel_which = '0;
        sel_ent   = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (s1_cur[i]) begin
                sel_multi = sel_multi | sel_hit;
                sel_hit   = 1'b1;
                sel_which = 6'(i);
                sel_ent   = entries[i];
            end
        end
    end

    // On a miss the selected entry is all zero, so only the page offset survives.
    always_comb begin
        res          = '0;
        res.miss     = !sel_hit;
        res.which    = sel_which;
        if (s1_vaddr[12]) begin
            res.phy_addr   = {sel_ent.pfn1, s1_vaddr[11:0]};
            res.dirty      = sel_ent.d1;
            res.valid      = sel_ent.v1;
            res.cache_flag = sel_ent.c1;
        end else begin
            res.phy_addr   = {sel_ent.pfn0, s1_vaddr[11:0]};
            res.dirty      = sel_ent.d0;
            res.valid      = sel_ent.v0;
            res.cache_flag = sel_ent.c0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_stale <= 1'b0;
            s1_vaddr <= '0;
            s1_match <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s1_stale <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_vaddr <= req_vaddr;
            s1_match <= match_vec(req_vaddr, entries, asid);
            s1_stale <= tlb_we;
        end else if (s1_xfer) begin
            s1_valid <= 1'b0;
            s1_stale <= 1'b0;
        end else if (s1_valid) begin
            if (tlb_we) begin
                s1_stale <= 1'b1;
            end else if (s1_stale) begin
                s1_match <= s1_cur;
                s1_stale <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_multi  <= 1'b0;
        end else if (flush) begin
            resp_valid  <= 1'b0;
        end else if (s1_xfer) begin
            resp_valid  <= 1'b1;
            resp_result <= res;
            resp_multi  <= sel_multi;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (resp_valid && resp_ready) begin
            if (!resp_result.miss && hit_cnt != '1)
                hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (resp_result.miss && miss_cnt != '1)
                miss_cnt <= miss_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

module tlb_lookup_pipe
    import tlb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PORTS   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  tlb_entry_t [ENTRIES-1:0]     entries,
    input  logic                         tlb_we,
    input  logic [7:0]                   asid,
    input  logic [PORTS-1:0]             req_valid,
    input  logic [PORTS-1:0][31:0]       req_vaddr,
    output logic [PORTS-1:0]             req_ready,
    output logic [PORTS-1:0]             resp_valid,
    input  logic [PORTS-1:0]             resp_ready,
    output tlb_result_t [PORTS-1:0]      resp_result,
    output logic [PORTS-1:0]             resp_multi,
    output logic [PORTS-1:0][CNT_W-1:0]  hit_cnt,
    output logic [PORTS-1:0][CNT_W-1:0]  miss_cnt
);
    for (genvar p = 0; p < PORTS; p++) begin : g_lane
        tlb_lookup_lane #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .entries     (entries),
            .tlb_we      (tlb_we),
            .asid        (asid),
            .req_valid   (req_valid[p]),
            .req_vaddr   (req_vaddr[p]),
            .req_ready   (req_ready[p]),
            .resp_valid  (resp_valid[p]),
            .resp_ready  (resp_ready[p]),
            .resp_result (resp_result[p]),
            .resp_multi  (resp_multi[p]),
            .hit_cnt     (hit_cnt[p]),
            .miss_cnt    (miss_cnt[p])
        );
    end
endmodule

// File: tb/tb_tlb_lookup_pipe.sv
// Directed plus randomized bench for tlb_lookup_pipe with an in-order per-port scoreboard.
module tb_tlb_lookup_pipe;
    import tlb_pkg::*;

    localparam int ENTRIES = 16;
    localparam int PORTS   = 2;
    localparam int CNT_W   = 32;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, tlb_we = 1'b0;
    logic [7:0] asid = '0;
    tlb_entry_t [ENTRIES-1:0] ents = '0;
    logic [PORTS-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0, resp_multi;
    logic [PORTS-1:0][31:0] req_vaddr = '0;
    tlb_result_t [PORTS-1:0] resp_result;
    logic [PORTS-1:0][CNT_W-1:0] hit_cnt, miss_cnt;

    logic [0:0] s_req_valid = 1'b0, s_req_ready, s_resp_valid, s_resp_ready = 1'b1, s_resp_multi;
    logic [0:0][31:0] s_vaddr = '0;
    tlb_result_t [0:0] s_res;
    logic [0:0][3:0] s_hit, s_miss;

    tlb_lookup_pipe #(.ENTRIES(ENTRIES), .PORTS(PORTS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .entries(ents), .tlb_we(tlb_we), .asid(asid),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_multi(resp_multi), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    tlb_lookup_pipe #(.ENTRIES(ENTRIES), .PORTS(1), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .entries(ents), .tlb_we(tlb_we), .asid(asid),
        .req_valid(s_req_valid), .req_vaddr(s_vaddr), .req_ready(s_req_ready),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready), .resp_result(s_res),
        .resp_multi(s_resp_multi), .hit_cnt(s_hit), .miss_cnt(s_miss));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [31:0] exp_q[PORTS][$];
    longint exp_hit[PORTS], exp_miss[PORTS];
    logic [PORTS-1:0] acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference lookup: first matching entry in index order, odd/even page by bit 12.
    function automatic void model(input logic [31:0] va, output tlb_result_t r, output logic multi);
        int n = 0;
        r = '0;
        r.miss = 1'b1;
        r.phy_addr = {20'h0, va[11:0]};
        for (int i = 0; i < ENTRIES; i++) begin
            if (ents[i].vpn2 == va[31:13] && (ents[i].asid == asid || ents[i].g)) begin
                if (n == 0) begin
                    r.miss  = 1'b0;
                    r.which = 6'(i);
                    if (va[12]) begin
                        r.phy_addr = {ents[i].pfn1, va[11:0]};
                        r.dirty = ents[i].d1; r.valid = ents[i].v1; r.cache_flag = ents[i].c1;
                    end else begin
                        r.phy_addr = {ents[i].pfn0, va[11:0]};
                        r.dirty = ents[i].d0; r.valid = ents[i].v0; r.cache_flag = ents[i].c0;
                    end
                end
                n++;
            end
        end
        multi = (n > 1);
    endfunction

    task automatic step();
        tlb_result_t r;
        logic m;
        logic [31:0] va;
        @(negedge clk);
        acc = '0;
        if (rst_n) begin
            for (int p = 0; p < PORTS; p++) begin
                if (resp_valid[p] && resp_ready[p]) begin
                    chk($sformatf("p%0d_resp_expected", p), 64'(exp_q[p].size() != 0), 64'd1);
                    if (exp_q[p].size() != 0) begin
                        va = exp_q[p].pop_front();
                        model(va, r, m);
                        chk($sformatf("p%0d_result va=%0h", p, va), 64'(resp_result[p]), 64'(r));
                        chk($sformatf("p%0d_multi va=%0h", p, va), 64'(resp_multi[p]), 64'(m));
                        if (r.miss) exp_miss[p]++; else exp_hit[p]++;
                    end
                end
                if (req_valid[p] && req_ready[p]) begin
                    exp_q[p].push_back(req_vaddr[p]);
                    acc[p] = 1'b1;
                end
            end
            if (flush)
                for (int p = 0; p < PORTS; p++) exp_q[p].delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input tlb_entry_t e);
        ents[idx] = e;
        tlb_we = 1'b1;
        step();
        tlb_we = 1'b0;
    endtask

    task automatic send(input int p, input logic [31:0] va, input int exp_lat,
                        output tlb_result_t res, output logic multi);
        int lat;
        req_valid[p] = 1'b1;
        req_vaddr[p] = va;
        step();
        req_valid[p] = 1'b0;
        lat = 1;
        while (!resp_valid[p] && lat < 8) begin
            step();
            lat++;
        end
        chk($sformatf("p%0d_latency va=%0h", p, va), 64'(lat), 64'(exp_lat));
        res = resp_result[p];
        multi = resp_multi[p];
        step();
    endtask

    initial begin
        tlb_entry_t e;
        tlb_result_t r, exp_r, cap;
        logic m;
        int k;

        for (int p = 0; p < PORTS; p++) begin exp_hit[p] = 0; exp_miss[p] = 0; end
        repeat (3) step();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_multi", 64'(resp_multi), 64'd0);
        chk("rst_result0", 64'(resp_result[0]), 64'd0);
        chk("rst_hit0", 64'(hit_cnt[0]), 64'd0);
        chk("rst_miss1", 64'(miss_cnt[1]), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h3);

        // Single hit on entry 3
        e = '0; e.vpn2 = 19'h200; e.asid = 8'd5; e.pfn0 = 20'h12345; e.v0 = 1'b1; e.d0 = 1'b1; e.c0 = 3'd3;
        asid = 8'd5;
        wr(3, e);
        resp_ready = '1;
        send(0, 32'h0040_0ABC, 2, r, m);
        exp_r = '0; exp_r.which = 6'd3; exp_r.phy_addr = 32'h1234_5ABC;
        exp_r.dirty = 1'b1; exp_r.valid = 1'b1; exp_r.cache_flag = 3'd3;
        chk("t1_result", 64'(r), 64'(exp_r));
        chk("t1_hit_cnt", 64'(hit_cnt[0]), 64'd1);

        // ASID mismatch, then global
        asid = 8'd6;
        send(0, 32'h0040_0ABC, 2, r, m);
        chk("t2_miss", 64'(r.miss), 64'd1);
        step();
        chk("t2_miss_cnt", 64'(miss_cnt[0]), 64'd1);
        e.g = 1'b1;
        wr(3, e);
        send(0, 32'h0040_0ABC, 2, r, m);
        chk("t2_global_hit", 64'(r.miss), 64'd0);

        // Two matching entries: lowest index wins, multi flagged
        e = '0; e.vpn2 = 19'h200; e.g = 1'b1; e.pfn1 = 20'hAAAAA; e.v1 = 1'b1;
        wr(2, e);
        e.pfn1 = 20'hBBBBB;
        wr(7, e);
        send(1, 32'h0040_1000, 2, r, m);
        chk("t3_which", 64'(r.which), 64'd2);
        chk("t3_phy", 64'(r.phy_addr), 64'hAAAA_A000);
        chk("t3_multi", 64'(m), 64'd1);
        wr(2, '0);
        wr(7, '0);

        // Streaming on both ports, one response per cycle per port
        for (k = 0; k < 10; k++) begin
            for (int p = 0; p < PORTS; p++) begin
                req_valid[p] = (k < 8);
                req_vaddr[p] = 32'h0040_0000 + 32'((k % 2) * 32'h1000) + 32'(p * 32'h2000) + 32'(k * 4);
            end
            step();
            if (k >= 1 && k <= 8) chk($sformatf("stream_valid k=%0d", k), 64'(resp_valid), 64'h3);
        end
        chk("stream_drained", 64'(resp_valid), 64'd0);

        // Backpressure: two accepted then stall, output held
        resp_ready = '0;
        req_valid[0] = 1'b1; req_vaddr[0] = 32'h0040_0010;
        step();
        req_vaddr[0] = 32'h0040_1020;
        step();
        req_vaddr[0] = 32'h0040_0030;
        chk("bp_req_ready_c2", 64'(req_ready[0]), 64'd0);
        chk("bp_resp_valid", 64'(resp_valid[0]), 64'd1);
        cap = resp_result[0];
        step();
        chk("bp_req_ready_c3", 64'(req_ready[0]), 64'd0);
        chk("bp_stable_c3", 64'(resp_result[0]), 64'(cap));
        step();
        chk("bp_stable_c4", 64'(resp_result[0]), 64'(cap));
        resp_ready = '1;
        step();
        req_valid[0] = 1'b0;
        repeat (4) step();
        chk("bp_no_loss", 64'(exp_q[0].size()), 64'd0);

        // TLB write while the lookup sits in s1
        req_valid[0] = 1'b1; req_vaddr[0] = 32'h0040_0ABC;
        step();
        req_valid[0] = 1'b0;
        ents[3].pfn0 = 20'h54321;
        tlb_we = 1'b1;
        step();
        tlb_we = 1'b0;
        chk("stale_c2_valid", 64'(resp_valid[0]), 64'd0);
        step();
        chk("stale_c3_valid", 64'(resp_valid[0]), 64'd1);
        chk("stale_c3_phy", 64'(resp_result[0].phy_addr), 64'h5432_1ABC);
        step();

        // Flush with both stages full
        resp_ready = '0;
        req_valid = '1; req_vaddr[0] = 32'h0040_0100; req_vaddr[1] = 32'h0040_1200;
        step();
        req_vaddr[0] = 32'h0040_0300; req_vaddr[1] = 32'h0060_0000;
        step();
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 64'(req_ready), 64'd0);
        step();
        flush = 1'b0; req_valid = '0;
        chk("flush_resp_valid", 64'(resp_valid), 64'd0);
        step();
        chk("flush_s1_empty", 64'(resp_valid), 64'd0);
        chk("flush_hit0", 64'(hit_cnt[0]), 64'(exp_hit[0]));
        chk("flush_miss1", 64'(miss_cnt[1]), 64'(exp_miss[1]));
        resp_ready = '1;

        // Saturation on a 4-bit counter
        s_req_valid = 1'b1; s_vaddr[0] = 32'h0040_0ABC;
        repeat (20) step();
        s_req_valid = 1'b0;
        repeat (4) step();
        chk("sat_hit", 64'(s_hit[0]), 64'd15);
        chk("sat_miss", 64'(s_miss[0]), 64'd0);

        // Reset in the middle of traffic
        req_valid = '1; req_vaddr[0] = 32'h0040_0ABC; req_vaddr[1] = 32'h0040_0DEF;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_res1", 64'(resp_result[1]), 64'd0);
        chk("mid_rst_hit0", 64'(hit_cnt[0]), 64'd0);
        chk("mid_rst_sat", 64'(s_hit[0]), 64'd0);
        req_valid = '0;
        for (int p = 0; p < PORTS; p++) begin exp_q[p].delete(); exp_hit[p] = 0; exp_miss[p] = 0; end
        step();
        rst_n = 1'b1;
        step();

        // Randomized traffic against the scoreboard, entries fixed per run
        for (int i = 0; i < ENTRIES; i++) begin
            e = '0;
            e.vpn2 = 19'($urandom_range(0, 7)); e.asid = 8'($urandom_range(0, 3)); e.g = 1'($urandom);
            e.pfn0 = 20'($urandom); e.pfn1 = 20'($urandom);
            e.c0 = 3'($urandom); e.c1 = 3'($urandom);
            e.d0 = 1'($urandom); e.d1 = 1'($urandom); e.v0 = 1'($urandom); e.v1 = 1'($urandom);
            ents[i] = e;
        end
        asid = 8'($urandom_range(0, 3));
        tlb_we = 1'b1;
        step();
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (!req_valid[p] || acc[p]) begin
                    req_valid[p] = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 3) != 0)
                        req_vaddr[p] = {ents[$urandom_range(0, ENTRIES-1)].vpn2, 13'($urandom)};
                    else
                        req_vaddr[p] = $urandom;
                end
                resp_ready[p] = ($urandom_range(0, 3) != 0);
            end
            tlb_we = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 49) == 0);
            step();
        end
        req_valid = '0; tlb_we = 1'b0; flush = 1'b0; resp_ready = '1;
        repeat (6) step();
        for (int p = 0; p < PORTS; p++) begin
            chk($sformatf("rand_q_empty p%0d", p), 64'(exp_q[p].size()), 64'd0);
            chk($sformatf("rand_hit p%0d", p), 64'(hit_cnt[p]), 64'(exp_hit[p]));
            chk($sformatf("rand_miss p%0d", p), 64'(miss_cnt[p]), 64'(exp_miss[p]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
